// File: rtl/batch_cycle_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : batch_cycle_scheduler_if
// Description : Handshake and address bus between the batch filter datapath
//               and the batch cycle scheduler. The master drives sample
//               acceptance and flush; the slave returns the registered
//               address set, batch strobe and warm-up qualifiers.
// Revision    : 1.0 - initial release
// ============================================================================
interface batch_cycle_scheduler_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic              flush;
  logic [ADDR_W-1:0] addr_wr;
  logic [ADDR_W-1:0] addr_lh;
  logic [ADDR_W-1:0] addr_fr;
  logic [ADDR_W-1:0] addr_br;
  logic              addr_en;
  logic              batch_end;
  logic              propagate;
  logic              compute_valid;
  logic              out_valid;

  modport master (
    output in_valid, flush,
    input  addr_wr, addr_lh, addr_fr, addr_br, addr_en,
    input  batch_end, propagate, compute_valid, out_valid
  );

  modport slave (
    input  in_valid, flush,
    output addr_wr, addr_lh, addr_fr, addr_br, addr_en,
    output batch_end, propagate, compute_valid, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/batch_cycle_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : batch_cycle_scheduler
// Description : Stallable, flushable address and phase sequencer for the
//               four-bank circular sample memory of the two-stage batch
//               filter. Produces write / lookahead / forward / backward
//               addresses per accepted sample, rotates banks at each batch
//               boundary and raises the warm-up qualifiers.
// Option      : define BATCH_SCHED_PROP_EN to build the sample-counted
//               propagate delay; otherwise propagate is tied high.
// Revision    : 1.0 - initial release
// ============================================================================
module batch_cycle_scheduler #(
  parameter int DEPTH      = 36,
  parameter int PROP_DELAY = 9,
  parameter int CNT_W      = $clog2(DEPTH),
  parameter int ADDR_W     = CNT_W + 2
) (
  input  wire                     clk,
  input  wire                     rst,
  batch_cycle_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DEPTH - 1);
  localparam logic [2:0]       c_NB_MAX = 3'd5;

  typedef enum logic [1:0] {
    ST_WARM = 2'd0,
    ST_COMP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  // Elaboration-time parameter sanity checks
  if (DEPTH < 2) begin : g_depth_check
    $error("batch_cycle_scheduler: DEPTH must be at least 2");
  end
  if ((PROP_DELAY < 0) || (PROP_DELAY > DEPTH - 1)) begin : g_prop_check
    $error("batch_cycle_scheduler: PROP_DELAY must lie in 0..DEPTH-1");
  end

  logic [CNT_W-1:0]  r_cnt;
  logic [1:0]        r_bank_wr;
  logic [1:0]        r_bank_calc;
  logic [1:0]        r_bank_idle;
  logic [1:0]        r_bank_lh;
  logic [2:0]        r_nb;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr_wr;
  logic [ADDR_W-1:0] r_addr_lh;
  logic [ADDR_W-1:0] r_addr_fr;
  logic [ADDR_W-1:0] r_addr_br;
  logic              r_addr_en;
  logic              r_batch_end;
  logic              r_compute_valid;
  logic              r_out_valid;

  logic [CNT_W-1:0]  w_rev;
  logic              w_accept;
  logic              w_wrap;
  logic [2:0]        w_nb_next;

  // A flush takes priority over a coincident sample, which is then dropped
  assign w_accept  = bus.in_valid & ~bus.flush;
  assign w_wrap    = w_accept && (r_cnt == c_LAST);
  assign w_rev     = c_LAST - r_cnt;
  assign w_nb_next = (r_nb == c_NB_MAX) ? c_NB_MAX : r_nb + 3'd1;

  // Sample counter, bank rotation and registered address set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bank_wr   <= 2'd0;
      r_bank_calc <= 2'd1;
      r_bank_idle <= 2'd2;
      r_bank_lh   <= 2'd3;
      r_addr_wr   <= '0;
      r_addr_lh   <= '0;
      r_addr_fr   <= '0;
      r_addr_br   <= '0;
      r_addr_en   <= 1'b0;
      r_batch_end <= 1'b0;
    end else if (bus.flush) begin
      r_cnt       <= '0;
      r_bank_wr   <= 2'd0;
      r_bank_calc <= 2'd1;
      r_bank_idle <= 2'd2;
      r_bank_lh   <= 2'd3;
      r_addr_en   <= 1'b0;
      r_batch_end <= 1'b0;
    end else begin
      r_addr_en   <= bus.in_valid;
      r_batch_end <= w_wrap;
      if (bus.in_valid) begin
        // Addresses use the pre-increment count and banks of this sample
        r_addr_wr <= {r_cnt, r_bank_wr};
        r_addr_lh <= {w_rev, r_bank_lh};
        r_addr_fr <= {r_cnt, r_bank_calc};
        r_addr_br <= {w_rev, r_bank_calc};
        if (w_wrap) begin
          r_cnt       <= '0;
          r_bank_wr   <= r_bank_wr + 2'd1;
          r_bank_calc <= r_bank_calc + 2'd1;
          r_bank_idle <= r_bank_idle + 2'd1;
          r_bank_lh   <= r_bank_lh + 2'd1;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Warm-up FSM: batch tally drives WARM -> COMP -> RUN, qualifiers registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= ST_WARM;
      r_nb            <= 3'd0;
      r_compute_valid <= 1'b0;
      r_out_valid     <= 1'b0;
    end else if (bus.flush) begin
      r_state         <= ST_WARM;
      r_nb            <= 3'd0;
      r_compute_valid <= 1'b0;
      r_out_valid     <= 1'b0;
    end else if (w_wrap) begin
      r_nb <= w_nb_next;
      case (r_state)
        ST_WARM: begin
          if (w_nb_next >= 3'd3) begin
            r_state         <= ST_COMP;
            r_compute_valid <= 1'b1;
          end
        end
        ST_COMP: begin
          if (w_nb_next == c_NB_MAX) begin
            r_state     <= ST_RUN;
            r_out_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state         <= ST_WARM;
          r_compute_valid <= 1'b0;
          r_out_valid     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BATCH_SCHED_PROP_EN
  localparam logic [CNT_W-1:0] c_PD      = CNT_W'(PROP_DELAY);
  localparam logic             c_PD_ZERO = (PROP_DELAY == 0);

  logic [CNT_W-1:0] r_pd_cnt;
  logic             r_pd_act;
  logic             r_prop;

  // Sample-counted delay from batch end to the single-sample propagate low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pd_cnt <= '0;
      r_pd_act <= 1'b0;
      r_prop   <= 1'b1;
    end else if (bus.flush) begin
      r_pd_cnt <= '0;
      r_pd_act <= 1'b0;
      r_prop   <= 1'b1;
    end else if (w_accept) begin
      if (w_wrap) begin
        // A new batch end always restarts the delay
        if (c_PD_ZERO) begin
          r_prop   <= 1'b0;
          r_pd_act <= 1'b0;
        end else begin
          r_prop   <= 1'b1;
          r_pd_act <= 1'b1;
          r_pd_cnt <= c_PD;
        end
      end else if (r_pd_act && (r_pd_cnt == CNT_W'(1))) begin
        r_prop   <= 1'b0;
        r_pd_act <= 1'b0;
      end else begin
        r_prop <= 1'b1;
        if (r_pd_act) begin
          r_pd_cnt <= r_pd_cnt - CNT_W'(1);
        end
      end
    end
  end

  assign bus.propagate = r_prop;
`else
  assign bus.propagate = 1'b1;
`endif

  assign bus.addr_wr       = r_addr_wr;
  assign bus.addr_lh       = r_addr_lh;
  assign bus.addr_fr       = r_addr_fr;
  assign bus.addr_br       = r_addr_br;
  assign bus.addr_en       = r_addr_en;
  assign bus.batch_end     = r_batch_end;
  assign bus.compute_valid = r_compute_valid;
  assign bus.out_valid     = r_out_valid;

endmodule
`default_nettype wire

// File: doc/batch_cycle_scheduler.md
# batch_cycle_scheduler

Address and phase sequencer for the two-stage batch filter's four-bank circular sample memory. Each accepted input sample produces one registered address set: a write address, a lookahead read address, a forward-recursion read address and a backward-recursion read address. Banks rotate at every batch boundary. The block also raises warm-up qualifiers (`compute_valid`, `out_valid`) and a lookahead-register propagate strobe. It runs on the recursion-rate clock and replaces the free-running counter and cycle logic inside the batch filter top level with a stallable, flushable controller.

## Interface
Parameters:
- `DEPTH`, 36: samples per batch segment, ≥2.
- `PROP_DELAY`, 9: samples from the batch-end acceptance to the propagate low pulse, 0..DEPTH-1.
- `CNT_W`, $clog2(DEPTH): batch counter width (derived; do not override).
- `ADDR_W`, CNT_W+2: sample memory address width (derived).

Ports:
- `clk`  in  1  recursion-rate clock, all logic on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  one new sample is accepted this cycle.
- `flush`  in  1  synchronous restart to the warm-up state.
- `addr_wr`  out  ADDR_W  write address, `{cnt, bank_wr}`.
- `addr_lh`  out  ADDR_W  lookahead read address, `{rev, bank_lh}`.
- `addr_fr`  out  ADDR_W  forward read address, `{cnt, bank_calc}`.
- `addr_br`  out  ADDR_W  backward read address, `{rev, bank_calc}`.
- `addr_en`  out  1  address set valid (registered copy of the accepted `in_valid`).
- `batch_end`  out  1  one-cycle pulse: the last sample of a batch was accepted.
- `propagate`  out  1  lookahead register propagate, active-high.
- `compute_valid`  out  1  recursions have valid history.
- `out_valid`  out  1  filter output is valid.

## Operation
- Counter `cnt` runs 0..DEPTH-1. It advances only when `in_valid`=1 and wraps to 0 after DEPTH-1. `rev` = DEPTH-1-cnt, computed combinationally.
- Bank pointers (2 bits each) reset to wr=0, calc=1, idle=2, lh=3. On the wrap acceptance, all four increment mod 4 in the same cycle, so the four banks stay pairwise distinct.
- Batch tally `nb` is a saturating counter 0..5, incremented on each wrap.
- FSM states:
  - WARM (nb<3): `compute_valid`=0, `out_valid`=0.
  - COMP (3≤nb<5): `compute_valid`=1, `out_valid`=0.
  - RUN (nb=5): both qualifiers 1.
- FSM transitions are WARM→COMP→RUN on the wrap that sets nb=3 and nb=5. RUN holds.
- `flush`=1 clears `cnt`, banks, `nb` and the FSM to their reset values on the next edge and suppresses `addr_en`/`batch_end` that cycle. If `flush` and `in_valid` arrive together, flush wins and the sample is dropped.
- With `in_valid`=0, all outputs except `addr_en` (which drops to 0) and `batch_end` hold their values.

## Timing
- All outputs are registered. Latency is 1 cycle from the accepting edge to `addr_*`/`addr_en`.
- Addresses carry the pre-increment `cnt` and banks of the accepted sample. The sample at `cnt`=DEPTH-1 is addressed with the old banks. The next sample uses `cnt`=0 and the new banks.
- `batch_end` is high in the same cycle as `addr_en` for the `cnt`=DEPTH-1 sample.
- Qualifiers change on the edge after the wrap acceptance, coincident with that `batch_end`.
- Reset values: `addr_*`=0 with banks at reset values, `addr_en`=0, `batch_end`=0, `propagate`=1, `compute_valid`=0, `out_valid`=0.
- Mid-operation reset clears everything asynchronously. The first sample after release is written to bank 0, `cnt`=0.

## Configuration
- `BATCH_SCHED_PROP_EN` defined:
  - A sample-counted delay counter starts at `batch_end`.
  - `propagate` goes low for exactly one accepted sample: the PROP_DELAY-th accepted sample after the batch-end acceptance. It is high otherwise.
  - Stalls freeze the delay counter.
  - A new `batch_end` arriving while the counter is still running restarts it.
  - `flush` clears the counter.
- `BATCH_SCHED_PROP_EN` undefined: `propagate` is constant 1 and no delay counter is built.

## Test plan
- Reset then 4 accepted samples, `DEPTH`=4: addr_wr = {0,0},{1,0},{2,0},{3,0}; addr_br = {3,1},{2,1},{1,1},{0,1}; `batch_end` high with the 4th sample only.
- 20 samples, `DEPTH`=4:
  - Banks (wr,calc,idle,lh) step (0,1,2,3)→(1,2,3,0)→…
  - `compute_valid` rises after the 12th sample.
  - `out_valid` rises after the 20th sample.
- `in_valid` toggled 1/0 pseudo-randomly: the address sequence is identical to the gap-free run, and `addr_en` is 0 on each idle cycle.
- `flush` together with `in_valid` at `cnt`=2 in RUN: sample dropped, FSM goes to WARM, next accepted sample gives addr_wr={0,0}, both qualifiers are 0.
- Async `rst` pulse mid-cycle (between edges): all outputs reach reset values immediately, without waiting for a clock edge.
- `BATCH_SCHED_PROP_EN`, `DEPTH`=4, `PROP_DELAY`=2: `propagate` is 0 only on the 2nd accepted sample after each `batch_end`. Without the macro, `propagate` stays at 1 throughout.
